register_op_scheduler: RTL and testbench
========================================

Name: register_op_scheduler

Overview:
- Shares one `register` datapath instance between NUM_REQ requesters.
- Round-robin arbitration picks one request at a time and drives the register's cl/ld/in/inc/dec/sr/ir/sl/il strobes.
- Multi-bit shifts run as a sequence of single-bit shift cycles.
- Sits between requester logic (bus/control FSMs) and the register; no requester touches register strobes directly.

Parameters:
- DATA_WIDTH, 16, width of the shared register and load data
- NUM_REQ, 4, number of requesters (2..8)
- SHAMT_W, 5, width of the per-request shift amount; must hold DATA_WIDTH

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- req  input  NUM_REQ  per-requester request level
- op  input  3*NUM_REQ  per-requester opcode, requester i at [3i+2:3i]
- data  input  DATA_WIDTH*NUM_REQ  per-requester load data
- amount  input  SHAMT_W*NUM_REQ  per-requester shift count
- fill  input  NUM_REQ  per-requester serial fill bit for shifts
- ack  output  NUM_REQ  one-hot completion pulse
- err  output  1  pulse alongside ack when the granted opcode was reserved
- busy  output  1  high while an operation is in progress
- gnt_id  output  $clog2(NUM_REQ)  index of the active/last granted requester
- reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il  output  1 each  register control strobes
- reg_in  output  DATA_WIDTH  register load data

Behaviour:
- Interface: one clock `clk`. Reset `rst` is asynchronous and active-high. While rst is high, all outputs are 0, state is IDLE, and the priority pointer is 0 (requester 0 highest).
- Opcodes:
  - 000 CLR: reg_cl
  - 001 LOAD: reg_ld, reg_in=data
  - 010 INC: reg_inc
  - 011 DEC: reg_dec
  - 100 SHR: reg_sr, reg_ir=fill
  - 101 SHL: reg_sl, reg_il=fill
  - 110/111 are reserved.
- All outputs come from registers. There is no combinational path from req/op/data to outputs.
- States are IDLE, EXEC, SHIFT.
- IDLE:
  - With req nonzero, pick the first set bit starting at the pointer, wrapping modulo NUM_REQ.
  - Latch its op, data, amount and fill, plus the winner index into gnt_id.
  - Next state is EXEC, except a shift with nonzero amount goes to SHIFT.
  - busy rises at that edge.
- EXEC lasts exactly one cycle:
  - Assert the single decoded strobe and ack[winner].
  - Return to IDLE; the pointer becomes winner+1 mod NUM_REQ.
- Reserved opcode: EXEC with no strobe and with ack and err both high.
- Shift with amount=0: EXEC with no strobe and ack only.
- SHIFT:
  - Count register is loaded with min(amount, DATA_WIDTH).
  - Each cycle asserts reg_sr/reg_sl (with reg_ir/reg_il = latched fill) and decrements the count.
  - ack[winner] is asserted in the cycle of the last shift strobe. Then go to IDLE and update the pointer.
  - A shift of k takes k strobe cycles.
- Exactly one strobe of cl/ld/inc/dec/sr/sl is high in any cycle, or none. The priority encoding inside the register is never relied upon.
- Request protocol:
  - Requesters hold req and operands stable from assertion until they see ack.
  - They drop req the cycle after ack.
  - An IDLE cycle always follows ack, so req high in that IDLE cycle is a new request.
  - Throughput is one single-cycle op per 2 cycles.
- Changes to req/operands of a non-granted requester while busy are ignored until IDLE.
- Asserting rst mid-SHIFT or mid-EXEC aborts immediately: strobes drop asynchronously, no ack is issued, and the pointer returns to 0.

Decomposition:
- Shared package: opcode constants (OP_CLR..OP_SHL), state encoding (ST_IDLE, ST_EXEC, ST_SHIFT).
- Sub-module rr_arbiter: parameter N; inputs req, pointer; outputs one-hot grant, index, any. Purely combinational, reusable elsewhere.
- The pointer register, FSM and operand latches stay in register_op_scheduler.

Test Plan:
- Reset then req=0001, op0=LOAD, data0=16'hA5A5 -> gnt_id=0, reg_ld=1 and reg_in=16'hA5A5 for one cycle 2 edges after req, ack=0001 in the same cycle, busy low the next cycle; attached register reads A5A5.
- req=1111, all INC, each requester drops req after ack -> grants in order 0,1,2,3, four reg_inc pulses, register counts +4, never two strobes in one cycle.
- op1=SHR, amount1=3, fill1=1 on register value 16'h0008 -> reg_sr high 3 consecutive cycles with reg_ir=1, ack[1] on the 3rd, register = 16'hE001.
- op2=SHL, amount2=20 (>16) -> exactly 16 reg_sl cycles, then ack.
- op2=SHL, amount2=0 -> no strobe, ack in one EXEC cycle.
- op3=3'b111 -> no strobe, ack[3] and err high together for one cycle.
- rst pulsed during the 2nd cycle of an 8-cycle SHL -> strobes drop asynchronously, no ack, busy=0; the next arbitration starts from requester 0.

Source files
------------

// File: rtl/register_op_scheduler_pkg.sv
// Shared opcode and state definitions for the register operation scheduler.
package register_op_scheduler_pkg;

  localparam logic [2:0] OP_CLR  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_SHR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [2:0] op_code);
    return (op_code == OP_SHR) || (op_code == OP_SHL);
  endfunction

endpackage

// File: rtl/register_op_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          any
);

  // Scan N positions starting at the pointer; the first hit wins.
  always_comb begin : scan
    int pos;
    grant = '0;
    index = '0;
    any   = 1'b0;
    pos   = 0;
    for (int i = 0; i < N; i++) begin
      pos = (int'(pointer) + i) % N;
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        index      = IW'(pos);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/register_op_scheduler.sv
// Arbitrates NUM_REQ requesters onto one shared register and sequences its control strobes.
module register_op_scheduler
  import register_op_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int SHAMT_W    = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [3*NUM_REQ-1:0]          op,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] data,
  input  logic [SHAMT_W*NUM_REQ-1:0]    amount,
  input  logic [NUM_REQ-1:0]            fill,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          err,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
  output logic                          reg_cl,
  output logic                          reg_ld,
  output logic                          reg_inc,
  output logic                          reg_dec,
  output logic                          reg_sr,
  output logic                          reg_ir,
  output logic                          reg_sl,
  output logic                          reg_il,
  output logic [DATA_WIDTH-1:0]         reg_in
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [SHAMT_W-1:0] SH_MAX = SHAMT_W'(DATA_WIDTH);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  state_t               state_r, state_n;
  logic [IW-1:0]        ptr_r, ptr_n;
  logic [2:0]           op_r, op_n;
  logic                 fill_r, fill_n;
  logic [SHAMT_W-1:0]   cnt_r, cnt_n;
  logic [IW-1:0]        gnt_n;
  logic [NUM_REQ-1:0]   ack_n;
  logic                 err_n, busy_n;
  logic                 cl_n, ld_n, inc_n, dec_n, sr_n, ir_n, sl_n, il_n;
  logic [DATA_WIDTH-1:0] in_n;

  logic [NUM_REQ-1:0]    win_grant;
  logic [IW-1:0]         win_idx;
  logic                  win_any;
  logic [2:0]            op_sel;
  logic [DATA_WIDTH-1:0] data_sel;
  logic [SHAMT_W-1:0]    amt_sel, amt_clamp;
  logic                  fill_sel;
  logic [IW-1:0]         ptr_after;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req     (req),
    .pointer (ptr_r),
    .grant   (win_grant),
    .index   (win_idx),
    .any     (win_any)
  );

  assign op_sel    = op[win_idx*3 +: 3];
  assign data_sel  = data[win_idx*DATA_WIDTH +: DATA_WIDTH];
  assign amt_sel   = amount[win_idx*SHAMT_W +: SHAMT_W];
  assign fill_sel  = fill[win_idx];
  assign amt_clamp = (amt_sel > SH_MAX) ? SH_MAX : amt_sel;
  assign ptr_after = (gnt_id == IW'(NUM_REQ - 1)) ? IW'(0) : gnt_id + IW'(1);

  // Next-state and next-output decode; outputs are registered one edge later.
  always_comb begin
    state_n = state_r;
    ptr_n   = ptr_r;
    op_n    = op_r;
    fill_n  = fill_r;
    cnt_n   = cnt_r;
    gnt_n   = gnt_id;
    ack_n   = '0;
    err_n   = 1'b0;
    busy_n  = 1'b0;
    cl_n    = 1'b0;
    ld_n    = 1'b0;
    inc_n   = 1'b0;
    dec_n   = 1'b0;
    sr_n    = 1'b0;
    ir_n    = 1'b0;
    sl_n    = 1'b0;
    il_n    = 1'b0;
    in_n    = '0;
    case (state_r)
      ST_IDLE: begin
        if (win_any) begin
          op_n   = op_sel;
          fill_n = fill_sel;
          gnt_n  = win_idx;
          busy_n = 1'b1;
          if (is_shift(op_sel) && (amt_sel != '0)) begin
            state_n = ST_SHIFT;
            cnt_n   = amt_clamp;
            if (op_sel == OP_SHR) begin
              sr_n = 1'b1;
              ir_n = fill_sel;
            end else begin
              sl_n = 1'b1;
              il_n = fill_sel;
            end
            if (amt_clamp == SHAMT_W'(1)) begin
              ack_n = win_grant;
            end else begin
              ack_n = '0;
            end
          end else begin
            state_n = ST_EXEC;
            ack_n   = win_grant;
            case (op_sel)
              OP_CLR:  cl_n = 1'b1;
              OP_LOAD: begin
                ld_n = 1'b1;
                in_n = data_sel;
              end
              OP_INC:  inc_n = 1'b1;
              OP_DEC:  dec_n = 1'b1;
              OP_SHR,
              OP_SHL:  err_n = 1'b0;
              default: err_n = 1'b1;
            endcase
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_n = ST_IDLE;
        ptr_n   = ptr_after;
      end
      ST_SHIFT: begin
        // cnt_r counts the strobe currently on the outputs plus those still to come.
        if (cnt_r == SHAMT_W'(1)) begin
          state_n = ST_IDLE;
          ptr_n   = ptr_after;
        end else begin
          cnt_n  = cnt_r - SHAMT_W'(1);
          busy_n = 1'b1;
          if (op_r == OP_SHR) begin
            sr_n = 1'b1;
            ir_n = fill_r;
          end else begin
            sl_n = 1'b1;
            il_n = fill_r;
          end
          if (cnt_r == SHAMT_W'(2)) begin
            ack_n = ONE_HOT0 << gnt_id;
          end else begin
            ack_n = '0;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, operand latches and registered outputs; reset aborts everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      op_r    <= 3'b000;
      fill_r  <= 1'b0;
      cnt_r   <= '0;
      gnt_id  <= '0;
      ack     <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
      reg_cl  <= 1'b0;
      reg_ld  <= 1'b0;
      reg_inc <= 1'b0;
      reg_dec <= 1'b0;
      reg_sr  <= 1'b0;
      reg_ir  <= 1'b0;
      reg_sl  <= 1'b0;
      reg_il  <= 1'b0;
      reg_in  <= '0;
    end else begin
      state_r <= state_n;
      ptr_r   <= ptr_n;
      op_r    <= op_n;
      fill_r  <= fill_n;
      cnt_r   <= cnt_n;
      gnt_id  <= gnt_n;
      ack     <= ack_n;
      err     <= err_n;
      busy    <= busy_n;
      reg_cl  <= cl_n;
      reg_ld  <= ld_n;
      reg_inc <= inc_n;
      reg_dec <= dec_n;
      reg_sr  <= sr_n;
      reg_ir  <= ir_n;
      reg_sl  <= sl_n;
      reg_il  <= il_n;
      reg_in  <= in_n;
    end
  end

endmodule

// File: tb/tb_register_op_scheduler.sv
// Scoreboard bench: stimulus queues expected completions, a monitor checks each ack and the register model.
module tb_register_op_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0;
  logic [11:0] op = 12'b0;
  logic [63:0] data = 64'b0;
  logic [19:0] amount = 20'b0;
  logic [3:0]  fill = 4'b0;
  logic [3:0]  ack;
  logic        err, busy;
  logic [1:0]  gnt_id;
  logic        reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il;
  logic [15:0] reg_in;

  typedef struct {
    logic [3:0]  ack;
    logic        err;
    logic [1:0]  gid;
    int          strobes;
    logic [15:0] regv;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          tmo = 0;
  logic        done = 1'b0;
  logic [15:0] model = 16'h0;

  register_op_scheduler #(.DATA_WIDTH(16), .NUM_REQ(4), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .data(data), .amount(amount), .fill(fill),
    .ack(ack), .err(err), .busy(busy), .gnt_id(gnt_id),
    .reg_cl(reg_cl), .reg_ld(reg_ld), .reg_inc(reg_inc), .reg_dec(reg_dec),
    .reg_sr(reg_sr), .reg_ir(reg_ir), .reg_sl(reg_sl), .reg_il(reg_il), .reg_in(reg_in)
  );

  always #5 clk = ~clk;

  // Behavioural model of the attached register.
  always @(posedge clk) begin
    if (reg_cl)       model <= 16'h0;
    else if (reg_ld)  model <= reg_in;
    else if (reg_inc) model <= model + 16'h1;
    else if (reg_dec) model <= model - 16'h1;
    else if (reg_sr)  model <= {reg_ir, model[15:1]};
    else if (reg_sl)  model <= {model[14:0], reg_il};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: reset-state checks, strobe exclusivity, ack scoreboard, post-op register value.
  initial begin : monitor
    int          scnt;
    int          ns;
    logic        pend;
    logic [15:0] pend_reg;
    exp_t        e;
    scnt = 0;
    pend = 1'b0;
    pend_reg = 16'h0;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        #1;
        chk("reset_outputs",
            {ack, err, busy, reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il, reg_in, gnt_id},
            32'h0);
        scnt = 0;
        pend = 1'b0;
      end else begin
        ns = int'(reg_cl) + int'(reg_ld) + int'(reg_inc) + int'(reg_dec) + int'(reg_sr) + int'(reg_sl);
        chk("one_strobe", 32'(ns > 1), 32'h0);
        scnt += ns;
        if (pend) begin
          chk("reg_value", 32'(model), 32'(pend_reg));
          chk("busy_after_ack", 32'(busy), 32'h0);
          pend = 1'b0;
        end
        if (ack != 4'b0) begin
          if (q.size() == 0) begin
            chk("unexpected_ack", 32'(ack), 32'h0);
          end else begin
            e = q.pop_front();
            chk("ack", 32'(ack), 32'(e.ack));
            chk("err", 32'(err), 32'(e.err));
            chk("gnt_id", 32'(gnt_id), 32'(e.gid));
            chk("strobe_count", 32'(scnt), 32'(e.strobes));
            pend = 1'b1;
            pend_reg = e.regv;
          end
          scnt = 0;
        end
      end
      if (done) begin
        chk("queue_drained", 32'(q.size()), 32'h0);
        chk("timeouts", 32'(tmo), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  function automatic exp_t mk(input logic [3:0] a, input logic e, input logic [1:0] g,
                              input int s, input logic [15:0] r);
    exp_t x;
    x.ack = a; x.err = e; x.gid = g; x.strobes = s; x.regv = r;
    return x;
  endfunction

  task automatic run(input logic [3:0] m);
    int n;
    n = 0;
    req = req | m;
    while (req != 4'b0 && n < 100) begin
      @(negedge clk);
      req = req & ~ack;
      n++;
    end
    if (req != 4'b0) begin
      tmo++;
      req = 4'b0;
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  // Directed stimulus.
  initial begin : stim
    int n;
    int seen;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    op[2:0] = 3'b001; data[15:0] = 16'hA5A5;
    q.push_back(mk(4'b0001, 1'b0, 2'd0, 1, 16'hA5A5));
    run(4'b0001);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    op = {3'b010, 3'b010, 3'b010, 3'b010};
    q.push_back(mk(4'b0001, 1'b0, 2'd0, 1, 16'hA5A6));
    q.push_back(mk(4'b0010, 1'b0, 2'd1, 1, 16'hA5A7));
    q.push_back(mk(4'b0100, 1'b0, 2'd2, 1, 16'hA5A8));
    q.push_back(mk(4'b1000, 1'b0, 2'd3, 1, 16'hA5A9));
    run(4'b1111);

    op[2:0] = 3'b001; data[15:0] = 16'h0008;
    q.push_back(mk(4'b0001, 1'b0, 2'd0, 1, 16'h0008));
    run(4'b0001);

    op[5:3] = 3'b100; amount[9:5] = 5'd3; fill[1] = 1'b1;
    q.push_back(mk(4'b0010, 1'b0, 2'd1, 3, 16'hE001));
    run(4'b0010);

    op[8:6] = 3'b101; amount[14:10] = 5'd20; fill[2] = 1'b0;
    q.push_back(mk(4'b0100, 1'b0, 2'd2, 16, 16'h0000));
    run(4'b0100);

    amount[14:10] = 5'd0;
    q.push_back(mk(4'b0100, 1'b0, 2'd2, 0, 16'h0000));
    run(4'b0100);

    op[11:9] = 3'b111;
    q.push_back(mk(4'b1000, 1'b1, 2'd3, 0, 16'h0000));
    run(4'b1000);

    op[2:0] = 3'b011;
    q.push_back(mk(4'b0001, 1'b0, 2'd0, 1, 16'hFFFF));
    run(4'b0001);

    op[5:3] = 3'b000;
    q.push_back(mk(4'b0010, 1'b0, 2'd1, 1, 16'h0000));
    run(4'b0010);

    // Abort an 8-step shift during its second strobe cycle.
    op[8:6] = 3'b101; amount[14:10] = 5'd8; fill[2] = 1'b1;
    req = 4'b0100;
    n = 0;
    seen = 0;
    while (seen < 2 && n < 20) begin
      @(negedge clk);
      if (reg_sl) seen++;
      n++;
    end
    if (seen < 2) tmo++;
    #2 rst = 1'b1;
    req = 4'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    op[5:3] = 3'b001; data[31:16] = 16'h1234;
    op[11:9] = 3'b001; data[63:48] = 16'h5678;
    q.push_back(mk(4'b0010, 1'b0, 2'd1, 1, 16'h1234));
    q.push_back(mk(4'b1000, 1'b0, 2'd3, 1, 16'h5678));
    run(4'b1010);

    repeat (3) @(negedge clk);
    done = 1'b1;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
